// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with a single registered output slot.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    handshake from fetch; in_ready = !out_valid || out_ready
//   in_instr, in_pc      instruction word and its address
//   flush                drops the held bundle and any instruction offered this cycle
//   out_valid/out_ready  handshake to execute
//   out_pc               registered in_pc
//   alu_sel              0 add, 1 sub, 2 pass op2, 3 sll, 4 srl, 5 sra,
//                        6 xor, 7 or, 8 and, 9 signed slt
//   imm                  decoded immediate (zero for illegal or R-type)
//   rs1, rs2, rd, funct3 raw instruction fields
//   op1_is_pc, op2_is_imm operand muxing for the ALU
//   reg_write, mem_read, mem_write, branch, jump  control flags
//   illegal              instruction could not be decoded
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        op1_is_pc,
  output logic        op2_is_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        op1_pc;
    logic        op2_imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } bundle_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  // Shift amounts are a plain 5-bit count, never sign-extended.
  function automatic logic [31:0] imm_sh(input logic [31:0] ins);
    return {27'b0, ins[24:20]};
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  bundle_t    bundle_d;
  bundle_t    bundle_q;
  logic       valid_d;
  logic       valid_q;
  logic       take_in;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    bundle_d         = '0;
    bundle_d.pc      = in_pc;
    bundle_d.rs1     = in_instr[19:15];
    bundle_d.rs2     = in_instr[24:20];
    bundle_d.rd      = in_instr[11:7];
    bundle_d.f3      = f3;
    unique case (opcode)
      OPC_LUI: begin
        bundle_d.alu     = ALU_PASS;
        bundle_d.imm     = imm_u(in_instr);
        bundle_d.op2_imm = 1'b1;
        bundle_d.rw      = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_d.alu     = ALU_ADD;
        bundle_d.imm     = imm_u(in_instr);
        bundle_d.op1_pc  = 1'b1;
        bundle_d.op2_imm = 1'b1;
        bundle_d.rw      = 1'b1;
      end
      OPC_JAL: begin
        bundle_d.alu     = ALU_ADD;
        bundle_d.imm     = imm_j(in_instr);
        bundle_d.op1_pc  = 1'b1;
        bundle_d.op2_imm = 1'b1;
        bundle_d.jp      = 1'b1;
        bundle_d.rw      = 1'b1;
      end
      OPC_JALR: begin
        bundle_d.alu     = ALU_ADD;
        bundle_d.imm     = imm_i(in_instr);
        bundle_d.op2_imm = 1'b1;
        bundle_d.jp      = 1'b1;
        bundle_d.rw      = 1'b1;
        bundle_d.ill     = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        bundle_d.alu = ALU_SUB;
        bundle_d.imm = imm_b(in_instr);
        bundle_d.br  = 1'b1;
        // funct3 010/011 are unassigned for branches.
        bundle_d.ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        bundle_d.alu     = ALU_ADD;
        bundle_d.imm     = imm_i(in_instr);
        bundle_d.op2_imm = 1'b1;
        bundle_d.mr      = 1'b1;
        bundle_d.rw      = 1'b1;
        // LB, LH, LW, LBU, LHU only.
        bundle_d.ill     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        bundle_d.alu     = ALU_ADD;
        bundle_d.imm     = imm_s(in_instr);
        bundle_d.op2_imm = 1'b1;
        bundle_d.mw      = 1'b1;
        // SB, SH, SW only.
        bundle_d.ill     = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        bundle_d.imm     = imm_i(in_instr);
        bundle_d.op2_imm = 1'b1;
        bundle_d.rw      = 1'b1;
        unique case (f3)
          3'b000: bundle_d.alu = ALU_ADD;
          3'b010: bundle_d.alu = ALU_SLT;
          3'b100: bundle_d.alu = ALU_XOR;
          3'b110: bundle_d.alu = ALU_OR;
          3'b111: bundle_d.alu = ALU_AND;
          3'b001: begin
            bundle_d.alu = ALU_SLL;
            bundle_d.imm = imm_sh(in_instr);
            bundle_d.ill = (f7 != F7_BASE);
          end
          3'b101: begin
            bundle_d.alu = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            bundle_d.imm = imm_sh(in_instr);
            bundle_d.ill = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
          default: bundle_d.ill = 1'b1;  // SLTIU
        endcase
      end
      OPC_OP: begin
        bundle_d.rw = 1'b1;
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000: bundle_d.alu = ALU_ADD;
            3'b001: bundle_d.alu = ALU_SLL;
            3'b010: bundle_d.alu = ALU_SLT;
            3'b100: bundle_d.alu = ALU_XOR;
            3'b101: bundle_d.alu = ALU_SRL;
            3'b110: bundle_d.alu = ALU_OR;
            3'b111: bundle_d.alu = ALU_AND;
            default: bundle_d.ill = 1'b1;  // SLTU
          endcase
        end else if (f7 == F7_ALT) begin
          unique case (f3)
            3'b000: bundle_d.alu = ALU_SUB;
            3'b101: bundle_d.alu = ALU_SRA;
            default: bundle_d.ill = 1'b1;
          endcase
        end else begin
          bundle_d.ill = 1'b1;
        end
      end
      default: bundle_d.ill = 1'b1;
    endcase

    // An illegal bundle must not cause any side effect downstream; only the
    // raw register/funct3 fields and pc are kept for trap reporting.
    if (bundle_d.ill) begin
      bundle_d.alu     = ALU_ADD;
      bundle_d.imm     = '0;
      bundle_d.op1_pc  = 1'b0;
      bundle_d.op2_imm = 1'b0;
      bundle_d.rw      = 1'b0;
      bundle_d.mr      = 1'b0;
      bundle_d.mw      = 1'b0;
      bundle_d.br      = 1'b0;
      bundle_d.jp      = 1'b0;
    end

    // Writes to x0 are architecturally discarded.
    if (bundle_d.rd == 5'd0) begin
      bundle_d.rw = 1'b0;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign take_in  = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (take_in) begin
        bundle_q <= bundle_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = bundle_q.pc;
  assign alu_sel    = bundle_q.alu;
  assign imm        = bundle_q.imm;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign funct3     = bundle_q.f3;
  assign op1_is_pc  = bundle_q.op1_pc;
  assign op2_is_imm = bundle_q.op2_imm;
  assign reg_write  = bundle_q.rw;
  assign mem_read   = bundle_q.mr;
  assign mem_write  = bundle_q.mw;
  assign branch     = bundle_q.br;
  assign jump       = bundle_q.jp;
  assign illegal    = bundle_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed RV32I vectors with hand-computed
// bundles queued into a scoreboard; a negedge monitor pops one entry per
// output handshake. Control behaviour (reset, stall, flush) is checked inline.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_sel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        op1_is_pc, op2_is_imm;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .alu_sel    (alu_sel),
    .imm        (imm),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .funct3     (funct3),
    .op1_is_pc  (op1_is_pc),
    .op2_is_imm (op2_is_imm),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .jump       (jump),
    .illegal    (illegal)
  );

  // Packed view of every bundle output: pc, alu, imm, rs1, rs2, rd, funct3,
  // then flags {op1_is_pc, op2_is_imm, reg_write, mem_read, mem_write,
  // branch, jump, illegal}.
  logic [93:0] act_v;
  assign act_v = {out_pc, alu_sel, imm, rs1, rs2, rd, funct3,
                  op1_is_pc, op2_is_imm, reg_write, mem_read, mem_write,
                  branch, jump, illegal};

  int n_tests = 0;
  int n_fail  = 0;
  logic [93:0] sb[$];

  function automatic logic [93:0] ev(input logic [31:0] pc, input logic [3:0] alu,
                                     input logic [31:0] im, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [4:0] d,
                                     input logic [2:0] f3, input logic [7:0] flg);
    return {pc, alu, im, r1, r2, d, f3, flg};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [93:0] e);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bundle: got %h expected none", act_v);
      end else begin
        check("bundle", {34'b0, act_v}, {34'b0, sb.pop_front()});
      end
    end
  end

  logic [93:0] e_ld, e_st;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFFD08293;
    in_pc     = 32'h0000_0040;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_outputs", {34'b0, act_v}, 128'd0);
    check("reset_valid", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream with execute always ready
    issue(32'hFFD08293, 32'h100, ev(32'h100, 4'd0, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 3'd0, 8'b01100000));
    issue(32'h405251B3, 32'h104, ev(32'h104, 4'd5, 32'h0, 5'd4, 5'd5, 5'd3, 3'd5, 8'b00100000));
    issue(32'h123450B7, 32'h108, ev(32'h108, 4'd2, 32'h12345000, 5'd8, 5'd3, 5'd1, 3'd5, 8'b01100000));
    issue(32'hFE208CE3, 32'h10C, ev(32'h10C, 4'd1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 3'd0, 8'b00000100));
    step();

    // Load held for three cycles while a store waits upstream
    e_ld = ev(32'h110, 4'd0, 32'h8, 5'd2, 5'd8, 5'd6, 3'd2, 8'b01110000);
    e_st = ev(32'h114, 4'd0, 32'hFFFFFFFC, 5'd2, 5'd7, 5'd28, 3'd2, 8'b01001000);
    out_ready = 1'b0;
    issue(32'h00812303, 32'h110, e_ld);
    in_valid = 1'b1;
    in_instr = 32'hFE712E23;
    in_pc    = 32'h114;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {127'b0, out_valid}, 128'd1);
      check("stall_in_ready", {127'b0, in_ready}, 128'd0);
      check("stall_hold", {34'b0, act_v}, {34'b0, e_ld});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    sb.push_back(e_st);
    step();
    in_valid = 1'b0;

    issue(32'h010000EF, 32'h118, ev(32'h118, 4'd0, 32'h10, 5'd0, 5'd16, 5'd1, 3'd0, 8'b11100010));
    issue(32'h00001517, 32'h11C, ev(32'h11C, 4'd0, 32'h1000, 5'd0, 5'd0, 5'd10, 3'd1, 8'b11100000));
    issue(32'h00008067, 32'h120, ev(32'h120, 4'd0, 32'h0, 5'd1, 5'd0, 5'd0, 3'd0, 8'b01000010));
    issue(32'h01F19193, 32'h124, ev(32'h124, 4'd3, 32'd31, 5'd3, 5'd31, 5'd3, 3'd1, 8'b01100000));
    issue(32'h41F1D193, 32'h128, ev(32'h128, 4'd5, 32'd31, 5'd3, 5'd31, 5'd3, 3'd5, 8'b01100000));
    issue(32'hFFFFFFFF, 32'h12C, ev(32'h12C, 4'd0, 32'h0, 5'd31, 5'd31, 5'd31, 3'd7, 8'b00000001));
    issue(32'h003130B3, 32'h130, ev(32'h130, 4'd0, 32'h0, 5'd2, 5'd3, 5'd1, 3'd3, 8'b00000001));
    issue(32'h403100B3, 32'h134, ev(32'h134, 4'd1, 32'h0, 5'd2, 5'd3, 5'd1, 3'd0, 8'b00100000));
    issue(32'h00512093, 32'h138, ev(32'h138, 4'd9, 32'h5, 5'd2, 5'd5, 5'd1, 3'd2, 8'b01100000));
    issue(32'h0062F233, 32'h13C, ev(32'h13C, 4'd8, 32'h0, 5'd5, 5'd6, 5'd4, 3'd7, 8'b00100000));

    // Flush drops an incoming instruction
    in_valid = 1'b1;
    flush    = 1'b1;
    in_instr = 32'hFFD08293;
    in_pc    = 32'h140;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("flush_incoming", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    #1;

    // Flush drops a held bundle as well as the incoming one
    out_ready = 1'b0;
    issue(32'hFFD08293, 32'h200, ev(32'h200, 4'd0, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 3'd0, 8'b01100000));
    in_valid = 1'b1;
    flush    = 1'b1;
    in_instr = 32'h123450B7;
    in_pc    = 32'h204;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    check("flush_held", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a stall
    issue(32'h123450B7, 32'h300, ev(32'h300, 4'd2, 32'h12345000, 5'd8, 5'd3, 5'd1, 3'd5, 8'b01100000));
    @(negedge clk);
    check("stall_before_rst", {127'b0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b1;
    in_instr = 32'h405251B3;
    in_pc    = 32'h304;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midstall_rst_outputs", {34'b0, act_v}, 128'd0);
    check("midstall_rst_valid", {127'b0, out_valid}, 128'd0);
    check("midstall_rst_ready", {127'b0, in_ready}, 128'd1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    issue(32'h0062F233, 32'h400, ev(32'h400, 4'd8, 32'h0, 5'd5, 5'd6, 5'd4, 3'd7, 8'b00100000));
    step();
    step();
    check("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  32  RV32I instruction word
- in_pc  in  32  instruction address
- in_ready  out  1  stage accepts this cycle
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- out_pc  out  32  registered in_pc
- alu_sel  out  4  ALU operation code
- imm  out  32  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- funct3  out  3  instr[14:12], passed through for branch and load/store width
- op1_is_pc  out  1  ALU op1 = pc, not rs1
- op2_is_imm  out  1  ALU op2 = imm, not rs2
- reg_write, mem_read, mem_write, branch, jump  out  1 each  control flags
- illegal  out  1  undecodable instruction

Function
REQ-003 The ALU codes SHALL be: 0000 add, 0001 sub, 0010 pass op2, 0011 sll, 0100 srl, 0101 sra, 0110 xor, 0111 or, 1000 and, 1001 signed slt.
REQ-004 The stage SHALL hold a single output register; in_ready = !out_valid || out_ready, combinational.
REQ-005 A transfer in (in_valid && in_ready) SHALL load all outputs and set out_valid on the next edge.
REQ-006 A transfer out (out_valid && out_ready) with no transfer in SHALL clear out_valid on the next edge.
REQ-007 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-008 flush SHALL clear out_valid on the next edge, overriding any simultaneous transfer in; the incoming instruction SHALL be dropped.
REQ-009 Decode by opcode in_instr[6:0]:
- 0110111 LUI: alu 0010, U-imm, op2_is_imm, reg_write.
- 0010111 AUIPC: alu 0000, U-imm, op1_is_pc, op2_is_imm, reg_write.
- 1101111 JAL: alu 0000, J-imm, op1_is_pc, op2_is_imm, jump, reg_write.
- 1100111 JALR with funct3=000: alu 0000, I-imm, op2_is_imm, jump, reg_write.
- 1100011 branch: alu 0001, B-imm, branch.
- 0000011 load: alu 0000, I-imm, op2_is_imm, mem_read, reg_write.
- 0100011 store: alu 0000, S-imm, op2_is_imm, mem_write.
- 0010011 OP-IMM: I-imm, op2_is_imm, reg_write; funct3 000 add, 010 slt, 100 xor, 110 or, 111 and, 001 sll (funct7=0000000), 101 srl (funct7=0000000) or sra (funct7=0100000).
- 0110011 OP: reg_write; funct7=0000000 selects 000 add, 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and; funct7=0100000 selects 000 sub, 101 sra.
REQ-010 For shift immediates, imm SHALL be zero-extended instr[24:20].
REQ-011 U-imm = {instr[31:12], 12'b0}; I, S, B and J immediates SHALL follow RV32I bit layout, sign-extended from instr[31]; B and J have bit 0 = 0.
REQ-012 illegal SHALL be set for any other opcode, funct3 or funct7, and for SLTU/SLTIU (funct3 011); illegal bundles SHALL have reg_write, mem_read, mem_write, branch and jump = 0, alu_sel 0000, imm 0.
REQ-013 rs1, rs2 and rd SHALL always be instr[19:15], [24:20] and [11:7]; reg_write SHALL be forced 0 when rd = 0.

Reset
REQ-014 On rst, out_valid SHALL be 0 and all other outputs SHALL be 0 on the next edge; rst SHALL override flush and transfers.
REQ-015 In the cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-016 addi x5,x1,-3 (0xFFD08293), out_ready=1 -> next cycle: out_valid=1, alu_sel 0000, imm 0xFFFFFFFD, rd 5, op2_is_imm=1, reg_write=1.
REQ-017 sra x3,x4,x5 (0x405251B3) -> alu_sel 0101, op2_is_imm=0; lui x1,0x12345 (0x123450B7) -> alu_sel 0010, imm 0x12345000.
REQ-018 beq x1,x2,-8 (0xFE208CE3) -> alu_sel 0001, imm 0xFFFFFFF8, branch=1, reg_write=0, funct3 000.
REQ-019 With out_ready=0 for 3 cycles after a load: outputs hold and in_ready=0; out_ready=1 with in_valid=1 -> back-to-back transfer, next bundle appears on the next edge.
REQ-020 flush together with in_valid=1 -> out_valid=0 next cycle; opcode 0x7F or sltu -> illegal=1 and all enables 0; rst asserted mid-stall -> all outputs 0.
